// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the CPU datapath and dmem.
// Sub-word stores are read-modify-write because dmem only writes whole 4-byte groups.
module lsu_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_e,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // RD    | dmem read of the 4 bytes at the captured address
    // CAP   | sample read data: extend for loads, merge for sub-word stores
    // WR    | dmem write of the word or merged data
    // RESP  | completion pulse
    // ERR   | error completion pulse, no dmem access
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] CAP  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] RESP = 3'd4;
    localparam logic [2:0] ERR  = 3'd5;

    localparam logic [1:0]    SZ_BYTE   = 2'b00;
    localparam logic [1:0]    SZ_HALF   = 2'b01;
    localparam logic [1:0]    SZ_WORD   = 2'b10;
    localparam logic [ADDR_W:0] LAST_BASE = (ADDR_W+1)'(MEM_BYTES - 4);

    logic [2:0]        state;
    logic              we_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              req_illegal;
    logic [31:0]       load_ext;
    logic [31:0]       merge_next;

    assign req_ready   = (state == IDLE) && !reset;
    assign accept      = req_valid && req_ready;
    // dmem always touches addr..addr+3, so the bound applies to every size
    assign req_illegal = (req_size == 2'b11) || ({1'b0, req_addr} > LAST_BASE);

    always_comb begin
        load_ext = mem_rdata;
        case (size_q)
            SZ_BYTE: load_ext = {{24{signed_q & mem_rdata[7]}}, mem_rdata[7:0]};
            SZ_HALF: load_ext = {{16{signed_q & mem_rdata[15]}}, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    assign merge_next = (size_q == SZ_BYTE) ? {mem_rdata[31:8], wdata_q[7:0]}
                                            : {mem_rdata[31:16], wdata_q[15:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q     <= req_we;
                        signed_q <= req_signed;
                        size_q   <= req_size;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (req_illegal) begin
                            rdata_q <= 32'h0;
                            err_q   <= 1'b1;
                            state   <= ERR;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD:  state <= CAP;
                CAP: begin
                    if (we_q) begin
                        merge_q <= merge_next;
                        state   <= WR;
                    end else begin
                        rdata_q <= load_ext;
                        err_q   <= 1'b0;
                        state   <= RESP;
                    end
                end
                WR: begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b0;
                    state   <= RESP;
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_e     = !reset && ((state == RD) || (state == WR));
    assign mem_rw    = !reset && (state == WR);
    assign mem_addr  = addr_q;
    assign mem_wdata = (size_q == SZ_WORD) ? wdata_q : merge_q;

    assign rsp_valid = (state == RESP) || (state == ERR);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl against a byte-array dmem model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_e;
    logic        mem_rw;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    lsu_ctrl #(.ADDR_W(10), .MEM_BYTES(1024)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_e(mem_e), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wd;
        logic [9:0]  wa;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          nchecks = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_issued = 0;
    int          ready_viol = 0;
    int          unexpected = 0;
    int          next_id = 0;
    logic [7:0]  mem [0:1023];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // dmem model: read data one cycle after the read, writes commit at the edge
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (mem_e && !mem_rw)
                mem_rdata <= {mem[(int'(mem_addr)+3)%1024], mem[(int'(mem_addr)+2)%1024],
                              mem[(int'(mem_addr)+1)%1024], mem[int'(mem_addr)]};
            if (mem_e && mem_rw)
                for (int k = 0; k < 4; k++)
                    mem[(int'(mem_addr)+k)%1024] <= mem_wdata[8*k +: 8];
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (!reset && req_valid && req_ready) n_acc++;
        end
    end

    // Monitor: tallies dmem cycles per transaction and checks each response
    initial begin
        int          cnt_rd;
        int          cnt_wr;
        logic [31:0] last_wd;
        logic [9:0]  last_wa;
        exp_t        e;
        cnt_rd = 0; cnt_wr = 0; last_wd = 32'h0; last_wa = 10'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt_rd = 0;
                cnt_wr = 0;
            end else begin
                if (mem_e && !mem_rw) cnt_rd++;
                if (mem_e && mem_rw) begin
                    cnt_wr++;
                    last_wd = mem_wdata;
                    last_wa = mem_addr;
                end
                if (req_ready == busy) ready_viol++;
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        unexpected++;
                        $display("FAIL unexpected_rsp: rdata=0x%08h err=%0b with nothing outstanding",
                                 rsp_rdata, rsp_err);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("t%0d rsp_rdata", e.id), rsp_rdata, e.rdata);
                        check($sformatf("t%0d rsp_err", e.id), 32'(rsp_err), 32'(e.err));
                        check($sformatf("t%0d latency", e.id), 32'(cyc - e.acc + 1), 32'(e.lat));
                        check($sformatf("t%0d dmem_reads", e.id), 32'(cnt_rd), 32'(e.nrd));
                        check($sformatf("t%0d dmem_writes", e.id), 32'(cnt_wr), 32'(e.nwr));
                        if (e.nwr > 0) begin
                            check($sformatf("t%0d wr_data", e.id), last_wd, e.wd);
                            check($sformatf("t%0d wr_addr", e.id), 32'(last_wa), 32'(e.wa));
                        end
                    end
                    cnt_rd = 0;
                    cnt_wr = 0;
                end
            end
        end
    end

    // Drive a request and hold req_valid until it is accepted; req_valid stays high
    task automatic issue(input bit we, input logic [1:0] sz, input bit sg, input logic [9:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input bit ee,
                         input int lat, input int nr, input int nw, input logic [31:0] ewd,
                         input bit track);
        int   guard;
        exp_t e;
        @(negedge clk);
        req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
            n_issued++;
            if (track) begin
                e.id = next_id; e.rdata = er; e.err = ee; e.lat = lat; e.nrd = nr; e.nwr = nw;
                e.wd = ewd; e.wa = a; e.acc = cyc;
                exp_q.push_back(e);
                next_id++;
            end
        end
    endtask

    task automatic release_req();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 10'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_mem_e", 32'(mem_e), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_reset_rsp_err", 32'(rsp_err), 32'd0);
        check("post_reset_rsp_rdata", rsp_rdata, 32'h0);
        check("post_reset_mem_addr", 32'(mem_addr), 32'h0);
        check("post_reset_mem_wdata", mem_wdata, 32'h0);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_req_ready", 32'(req_ready), 32'd1);

        // word store and load-back
        issue(1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 32'hDEADBEEF, 1);
        issue(0, 2'b10, 0, 10'h010, 32'h0,        32'hDEADBEEF, 0, 3, 1, 0, 32'h0, 1);
        // sb @0x011 re-reads bytes 0x011..0x014 = 0x00DEADBE, replaces low byte
        issue(1, 2'b00, 0, 10'h011, 32'h1234565A, 32'h0,        0, 4, 1, 1, 32'h00DEAD5A, 1);
        issue(0, 2'b00, 0, 10'h011, 32'h0,        32'h0000005A, 0, 3, 1, 0, 32'h0, 1);
        issue(0, 2'b10, 0, 10'h010, 32'h0,        32'hDEAD5AEF, 0, 3, 1, 0, 32'h0, 1);
        // halfword store then signed/unsigned sub-word loads
        issue(1, 2'b01, 0, 10'h020, 32'h000080F0, 32'h0,        0, 4, 1, 1, 32'h000080F0, 1);
        issue(0, 2'b01, 1, 10'h020, 32'h0,        32'hFFFF80F0, 0, 3, 1, 0, 32'h0, 1);
        issue(0, 2'b01, 0, 10'h020, 32'h0,        32'h000080F0, 0, 3, 1, 0, 32'h0, 1);
        issue(0, 2'b00, 1, 10'h020, 32'h0,        32'hFFFFFFF0, 0, 3, 1, 0, 32'h0, 1);
        // errors and the last legal base
        issue(0, 2'b10, 0, 10'h3FD, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0, 1);
        issue(1, 2'b11, 0, 10'h000, 32'h55555555, 32'h0,        1, 1, 0, 0, 32'h0, 1);
        issue(1, 2'b10, 0, 10'h3FC, 32'hCAFEF00D, 32'h0,        0, 2, 0, 1, 32'hCAFEF00D, 1);
        issue(0, 2'b10, 0, 10'h3FC, 32'h0,        32'hCAFEF00D, 0, 3, 1, 0, 32'h0, 1);

        // reset during CAP of a sub-word store: abort, no response, memory unchanged
        issue(1, 2'b01, 0, 10'h020, 32'h0000BEEF, 32'h0,        0, 4, 1, 1, 32'h0, 0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        issue(0, 2'b01, 0, 10'h020, 32'h0,        32'h000080F0, 0, 3, 1, 0, 32'h0, 1);

        // back-to-back with req_valid held high throughout
        issue(1, 2'b10, 0, 10'h100, 32'h11223344, 32'h0,        0, 2, 0, 1, 32'h11223344, 1);
        issue(0, 2'b00, 1, 10'h101, 32'h0,        32'h00000033, 0, 3, 1, 0, 32'h0, 1);
        issue(0, 2'b01, 1, 10'h102, 32'h0,        32'h00001122, 0, 3, 1, 0, 32'h0, 1);
        issue(1, 2'b00, 0, 10'h103, 32'hFFFFFF80, 32'h0,        0, 4, 1, 1, 32'h00000080, 1);
        issue(0, 2'b00, 1, 10'h103, 32'h0,        32'hFFFFFF80, 0, 3, 1, 0, 32'h0, 1);
        release_req();

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("outstanding_at_end", 32'(exp_q.size()), 32'd0);
        check("unexpected_responses", 32'(unexpected), 32'd0);
        check("ready_vs_busy_violations", 32'(ready_viol), 32'd0);
        check("accept_count", 32'(n_acc), 32'(n_issued));
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
